// File: rtl/requant_perchan_if.sv
// Valid/ready stream carrying a data word and a channel tag.
// The design uses one instance for accumulator input and one for requantized output.
interface requant_perchan_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CH_W   = 4
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   ch;

    modport master (output valid, output data, output ch, input ready);
    modport slave  (input valid, input data, input ch, output ready);
endinterface

// File: rtl/requant_perchan.sv
// Per-channel requantizer: acc * mult, rounding arithmetic right shift, zero-point offset,
// optional ReLU and saturation to OUT_W, as a two-stage valid/ready pipeline.
module requant_perchan #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned MULT_W  = 16,
    parameter int unsigned SHIFT_W = 6,
    parameter int unsigned NUM_CH  = 16,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we_i,
    input  logic [CH_W-1:0]          cfg_ch_i,
    input  logic signed [MULT_W-1:0] cfg_mult_i,
    input  logic [SHIFT_W-1:0]       cfg_shift_i,
    input  logic signed [OUT_W-1:0]  cfg_zp_i,
    input  logic                     relu_en_i,
    input  logic                     sat_clr_i,
    output logic [15:0]              sat_cnt_o,
    requant_perchan_if.slave         s_if,
    requant_perchan_if.master        m_if
);
    localparam int unsigned PW = IN_W + MULT_W;
    localparam int unsigned VW = PW + 2;

    logic signed [MULT_W-1:0] mult_q  [NUM_CH];
    logic [SHIFT_W-1:0]       shift_q [NUM_CH];
    logic signed [OUT_W-1:0]  zp_q    [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                mult_q[i]  <= '0;
                shift_q[i] <= '0;
                zp_q[i]    <= '0;
            end
        end else if (cfg_we_i && (32'(cfg_ch_i) < NUM_CH)) begin
            mult_q[cfg_ch_i]  <= cfg_mult_i;
            shift_q[cfg_ch_i] <= cfg_shift_i;
            zp_q[cfg_ch_i]    <= cfg_zp_i;
        end
    end

    // Out-of-range channels look up an all-zero entry so the beat still flows through as 0.
    logic signed [MULT_W-1:0] lk_mult;
    logic [SHIFT_W-1:0]       lk_shift;
    logic signed [OUT_W-1:0]  lk_zp;
    logic signed [PW-1:0]     prod_d;

    always_comb begin
        lk_mult  = '0;
        lk_shift = '0;
        lk_zp    = '0;
        if (32'(s_if.ch) < NUM_CH) begin
            lk_mult  = mult_q[s_if.ch];
            lk_shift = shift_q[s_if.ch];
            lk_zp    = zp_q[s_if.ch];
        end
        prod_d = PW'($signed(s_if.data)) * PW'(lk_mult);
    end

    logic                    v1_q;
    logic signed [PW-1:0]    prod_q;
    logic [SHIFT_W-1:0]      sh1_q;
    logic signed [OUT_W-1:0] zp1_q;
    logic                    relu1_q;
    logic [CH_W-1:0]         ch1_q;
    logic                    mv_q;
    logic [OUT_W-1:0]        mdata_q;
    logic [CH_W-1:0]         mch_q;
    logic [15:0]             sat_cnt_q, sat_cnt_d;
    logic                    adv1, adv2;

    assign adv2       = !mv_q || m_if.ready;
    assign adv1       = !v1_q || adv2;
    assign s_if.ready = adv1;

    // One extra bit absorbs the rounding addend; one more covers the zero-point add.
    logic signed [PW:0]      rnd_add, rnd_sum;
    logic signed [VW-1:0]    v, out_max, out_min, lo;
    logic [OUT_W-1:0]        clamp_d;
    logic                    sat;

    always_comb begin
        rnd_add = '0;
        if (sh1_q != '0) begin
            rnd_add = (PW+1)'(1) << (sh1_q - SHIFT_W'(1));
        end
        rnd_sum = (PW+1)'(prod_q) + rnd_add;
        rnd_sum = rnd_sum >>> sh1_q;
        v       = VW'(rnd_sum) + VW'(zp1_q);
        out_max = VW'({(OUT_W-1){1'b1}});
        out_min = ~out_max;
        lo      = (relu1_q && (VW'(zp1_q) > out_min)) ? VW'(zp1_q) : out_min;
        sat     = (v > out_max) || (v < out_min);
        if (v > out_max) begin
            clamp_d = OUT_W'(out_max);
        end else if (v < lo) begin
            clamp_d = OUT_W'(lo);
        end else begin
            clamp_d = OUT_W'(v);
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i) begin
            sat_cnt_d = '0;
        end else if (adv2 && v1_q && sat && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            prod_q    <= '0;
            sh1_q     <= '0;
            zp1_q     <= '0;
            relu1_q   <= 1'b0;
            ch1_q     <= '0;
            mv_q      <= 1'b0;
            mdata_q   <= '0;
            mch_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= s_if.valid;
                if (s_if.valid) begin
                    prod_q  <= prod_d;
                    sh1_q   <= lk_shift;
                    zp1_q   <= lk_zp;
                    relu1_q <= relu_en_i;
                    ch1_q   <= s_if.ch;
                end
            end
            if (adv2) begin
                mv_q <= v1_q;
                if (v1_q) begin
                    mdata_q <= clamp_d;
                    mch_q   <= ch1_q;
                end
            end
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign m_if.valid = mv_q;
    assign m_if.data  = mdata_q;
    assign m_if.ch    = mch_q;
    assign sat_cnt_o  = sat_cnt_q;
endmodule

// File: tb/tb_requant_perchan.sv
// Directed bench for requant_perchan: hand-computed vectors checked with immediate assertions.
module tb_requant_perchan;
    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_ch;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        relu;
    logic        sat_clr;
    logic [15:0] sat_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int idx;
    int cnt;

    logic [31:0] sd [4] = '{32'd10000, 32'd20, 32'd30, 32'd40};
    logic [7:0]  ed [4] = '{8'd18, 8'd21, 8'd32, 8'd40};
    logic [7:0]  od [$];
    logic [3:0]  oc [$];

    requant_perchan_if #(.DATA_W(32), .CH_W(4)) s_if ();
    requant_perchan_if #(.DATA_W(8), .CH_W(4))  m_if ();

    requant_perchan #(
        .IN_W(32), .OUT_W(8), .MULT_W(16), .SHIFT_W(6), .NUM_CH(12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we_i    (cfg_we),
        .cfg_ch_i    (cfg_ch),
        .cfg_mult_i  (cfg_mult),
        .cfg_shift_i (cfg_shift),
        .cfg_zp_i    (cfg_zp),
        .relu_en_i   (relu),
        .sat_clr_i   (sat_clr),
        .sat_cnt_o   (sat_cnt),
        .s_if        (s_if),
        .m_if        (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] ch, input logic [15:0] mult, input logic [5:0] sh,
                       input logic [7:0] zp);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mult = mult; cfg_shift = sh; cfg_zp = zp;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Single beat into an idle pipe: checks acceptance, 2-edge latency, data and channel tag.
    task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] ch,
                        input logic rl, input logic [7:0] exp);
        @(negedge clk);
        s_if.valid = 1'b1; s_if.data = d; s_if.ch = ch; relu = rl; m_if.ready = 1'b1;
        #1;
        chk({tag, "_s_ready"}, 32'(s_if.ready), 32'd1);
        @(negedge clk);
        s_if.valid = 1'b0;
        #1;
        chk({tag, "_early"}, 32'(m_if.valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, "_m_valid"}, 32'(m_if.valid), 32'd1);
        chk({tag, "_m_data"}, 32'(m_if.data), 32'(exp));
        chk({tag, "_m_ch"}, 32'(m_if.ch), 32'(ch));
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
        relu = 1'b0; sat_clr = 1'b0;
        s_if.valid = 1'b0; s_if.data = '0; s_if.ch = '0; m_if.ready = 1'b1;
        #12;
        chk("rst_m_valid", 32'(m_if.valid), 32'd0);
        chk("rst_m_data", 32'(m_if.data), 32'd0);
        chk("rst_m_ch", 32'(m_if.ch), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_s_ready", 32'(s_if.ready), 32'd1);

        beat("unconfigured", 32'd1234, 4'd7, 1'b0, 8'd0);

        cfg(4'd0, 16'd116, 6'd16, 8'd0);
        beat("pos10000", 32'd10000, 4'd0, 1'b0, 8'd18);
        beat("neg10000", -32'sd10000, 4'd0, 1'b0, -8'sd18);
        chk("sat_none", 32'(sat_cnt), 32'd0);
        beat("pos100000", 32'd100000, 4'd0, 1'b0, 8'd127);
        chk("sat_one", 32'(sat_cnt), 32'd1);
        beat("neg100000", -32'sd100000, 4'd0, 1'b0, -8'sd128);
        chk("sat_two", 32'(sat_cnt), 32'd2);
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        #1;
        chk("sat_clr", 32'(sat_cnt), 32'd0);

        cfg(4'd3, 16'd1, 6'd1, 8'd0);
        beat("round_pos3", 32'd3, 4'd3, 1'b0, 8'd2);
        beat("round_neg3", -32'sd3, 4'd3, 1'b0, -8'sd1);
        cfg(4'd3, 16'd1, 6'd0, 8'd0);
        beat("noshift300", 32'd300, 4'd3, 1'b0, 8'd127);
        chk("sat_300", 32'(sat_cnt), 32'd1);

        cfg(4'd5, 16'd1, 6'd0, 8'd5);
        beat("relu_neg20", -32'sd20, 4'd5, 1'b1, 8'd5);
        chk("relu_not_sat", 32'(sat_cnt), 32'd1);
        beat("relu_pos10", 32'd10, 4'd5, 1'b1, 8'd15);
        beat("norelu_neg20", -32'sd20, 4'd5, 1'b0, -8'sd15);

        cfg(4'd13, 16'd1, 6'd0, 8'd9);
        beat("bad_channel", 32'd500, 4'd13, 1'b0, 8'd0);

        // Backpressure: two beats fill the pipe, the rest must wait.
        cfg(4'd1, 16'd1, 6'd0, 8'd1);
        cfg(4'd2, 16'd1, 6'd0, 8'd2);
        m_if.ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            s_if.valid = 1'b1; s_if.data = sd[idx]; s_if.ch = 4'(idx);
            #1;
            if (s_if.ready) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'd2);
        chk("stall_s_ready", 32'(s_if.ready), 32'd0);
        chk("stall_m_data_held", 32'(m_if.data), 32'd18);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            m_if.ready = 1'b1;
            if (idx < 4) begin
                s_if.valid = 1'b1; s_if.data = sd[idx]; s_if.ch = 4'(idx);
            end else begin
                s_if.valid = 1'b0;
            end
            #1;
            if (m_if.valid) begin
                od.push_back(m_if.data);
                oc.push_back(m_if.ch);
            end
            if (idx < 4 && s_if.ready) idx++;
        end
        s_if.valid = 1'b0;
        chk("stall_out_count", 32'(od.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < od.size()) begin
                chk($sformatf("stall_out%0d_data", i), 32'(od[i]), 32'(ed[i]));
                chk($sformatf("stall_out%0d_ch", i), 32'(oc[i]), 32'(i));
            end
        end

        // Reset with two beats in flight.
        @(negedge clk);
        m_if.ready = 1'b0; s_if.valid = 1'b1; s_if.data = 32'd10000; s_if.ch = 4'd0;
        @(negedge clk);
        @(negedge clk);
        s_if.valid = 1'b0;
        #1;
        chk("flight_m_valid", 32'(m_if.valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_if.valid), 32'd0);
        chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; m_if.ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (m_if.valid) cnt++;
        end
        chk("midrst_no_output", 32'(cnt), 32'd0);

        // Config write and same-channel acceptance in one cycle: old entry applies.
        cfg(4'd2, 16'd1, 6'd0, 8'd0);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 4'd2; cfg_mult = 16'd1; cfg_shift = 6'd0; cfg_zp = 8'd50;
        s_if.valid = 1'b1; s_if.data = 32'd7; s_if.ch = 4'd2; relu = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        s_if.valid = 1'b0;
        #1;
        chk("samecyc_old_valid", 32'(m_if.valid), 32'd1);
        chk("samecyc_old_data", 32'(m_if.data), 32'd7);
        @(negedge clk);
        #1;
        chk("samecyc_new_data", 32'(m_if.data), 32'd57);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
